// File: rtl/matrix_scan_pkg.sv
// Shared constants for the key matrix scanner: FSM encoding, key-code width, event queue depth.
package matrix_scan_pkg;
  localparam int KEY_W      = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic logic [7:0] col_onehot(input logic [2:0] col);
    return 8'd1 << col;
  endfunction
endpackage

// File: rtl/key_fifo.sv
// 4x6 key-event queue: head visible combinationally, pop on valid&ready.
// A push into a full queue is taken only when a pop happens in the same cycle.
module key_fifo
  import matrix_scan_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [KEY_W-1:0] i_push_dat,
  output logic             o_pop_vld,
  output logic [KEY_W-1:0] o_pop_dat,
  input  logic             i_pop_rdy,
  output logic             o_full,
  output logic             o_empty
);
  localparam logic [FIFO_AW:0]   LP_FULL    = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   LP_CNT_ONE = 1;
  localparam logic [FIFO_AW-1:0] LP_PTR_ONE = 1;

  logic [KEY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_pop;
  logic               w_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LP_FULL);
  assign o_pop_vld = ~o_empty;
  assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_pop     = o_pop_vld & i_pop_rdy;
  assign w_push    = i_push_vld & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// 8x8 key matrix scanner with per-key debounce; press events are queued, dropped when the queue is full.
// Events appear one cycle after the debounce flip; o_overflow latches any drop until reset.
module matrix_scan_ctrl
  import matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int SETTLE   = 8,
  parameter int DEB_CNT  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_row_n,
  output logic [7:0]       o_col_n,
  output logic [7:0]       o_sync,
  output logic [7:0]       o_row_lvl,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  input  logic             i_key_ready,
  output logic             o_overflow
);
  localparam int             DW           = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  LP_DWELL_END = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  LP_SETTLE    = DW'(SETTLE);
  localparam logic [DW-1:0]  LP_DWELL_ONE = 1;
  localparam logic [2:0]     LP_DEB_LAST  = 3'(DEB_CNT - 1);

  logic [7:0]       r_row_s1;
  logic [7:0]       r_row_s2;
  logic [7:0]       r_snap;
  logic [1:0]       r_state;
  logic [DW-1:0]    r_dwell;
  logic [2:0]       r_col;
  logic [2:0]       r_row_idx;
  logic [63:0]      r_stable;
  logic [2:0]       r_cnt [64];
  logic             r_overflow;

  logic [KEY_W-1:0] w_key_idx;
  logic             w_eval;
  logic             w_raw;
  logic             w_differ;
  logic             w_flip;
  logic             w_push;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;

  assign w_key_idx = {r_col, r_row_idx};
  assign w_eval    = (r_state == ST_EVAL);
  assign w_raw     = ~r_snap[r_row_idx];
  assign w_differ  = (w_raw != r_stable[w_key_idx]);
  assign w_flip    = w_eval & w_differ & (r_cnt[w_key_idx] == LP_DEB_LAST);
  assign w_push    = w_flip & w_raw;
  assign w_pop     = ~w_fifo_empty & i_key_ready;

  assign o_sync     = col_onehot(r_col);
  assign o_col_n    = ~o_sync;
  assign o_row_lvl  = r_stable[{r_col, 3'b000} +: 8];
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_s1 <= 8'hFF;
      r_row_s2 <= 8'hFF;
    end else begin
      r_row_s1 <= i_row_n;
      r_row_s2 <= r_row_s1;
    end
  end

  // Column advance sits outside the case: the dwell end is only reachable from HOLD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_SETTLE;
      r_dwell   <= '0;
      r_col     <= '0;
      r_row_idx <= '0;
      r_snap    <= 8'hFF;
    end else begin
      if (r_dwell == LP_DWELL_END) begin
        r_dwell <= '0;
        r_col   <= r_col + 3'd1;
        r_state <= ST_SETTLE;
      end else begin
        r_dwell <= r_dwell + LP_DWELL_ONE;
      end
      case (r_state)
        ST_SETTLE: if (r_dwell == LP_SETTLE) begin
          r_snap    <= r_row_s2;
          r_row_idx <= '0;
          r_state   <= ST_EVAL;
        end
        ST_EVAL: begin
          r_row_idx <= r_row_idx + 3'd1;
          if (r_row_idx == 3'd7) r_state <= ST_HOLD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < 64; i++) r_cnt[i] <= '0;
    end else if (w_eval) begin
      if (!w_differ) begin
        r_cnt[w_key_idx] <= '0;
      end else if (w_flip) begin
        r_stable[w_key_idx] <= w_raw;
        r_cnt[w_key_idx]    <= '0;
      end else begin
        r_cnt[w_key_idx] <= r_cnt[w_key_idx] + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                r_overflow <= 1'b0;
    else if (w_push && w_fifo_full && !w_pop)    r_overflow <= 1'b1;
  end

  key_fifo u_key_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push_vld (w_push),
    .i_push_dat (w_key_idx),
    .o_pop_vld  (o_key_valid),
    .o_pop_dat  (o_key_code),
    .i_pop_rdy  (i_key_ready),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: directed key presses, expected codes queued, popped by a monitor.
module tb_matrix_scan_ctrl;
  localparam int FRAME = 8 * 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_row_n;
  logic [7:0] o_col_n;
  logic [7:0] o_sync;
  logic [7:0] o_row_lvl;
  logic [5:0] o_key_code;
  logic       o_key_valid;
  logic       i_key_ready;
  logic       o_overflow;

  logic [63:0] key_pressed = '0;
  logic [5:0]  exp_q[$];
  logic [5:0]  mon_exp;
  int          n_chk  = 0;
  int          n_pass = 0;

  matrix_scan_ctrl #(.SCAN_DIV(16), .SETTLE(4), .DEB_CNT(3)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_row_n     (i_row_n),
    .o_col_n     (o_col_n),
    .o_sync      (o_sync),
    .o_row_lvl   (o_row_lvl),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .i_key_ready (i_key_ready),
    .o_overflow  (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Physical matrix: a pressed key shorts its row to the driven (low) column.
  always_comb begin
    i_row_n = 8'hFF;
    for (int c = 0; c < 8; c++)
      if (!o_col_n[c])
        for (int r = 0; r < 8; r++)
          if (key_pressed[c*8+r]) i_row_n[r] = 1'b0;
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_key_valid && i_key_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_event", 32'(o_key_code), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        chk(o_key_code == mon_exp, "event_code", 32'(o_key_code), 32'(mon_exp));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic set_key(input int col, input int row, input bit v);
    key_pressed[col*8+row] = v;
  endtask

  // Returns one tick after the given column becomes active (dwell counter 0).
  task automatic wait_col_start(input logic [7:0] coln);
    int k = 0;
    while (o_col_n == coln && k < 300) begin step(1); k++; end
    while (o_col_n != coln && k < 300) begin step(1); k++; end
    chk(o_col_n == coln && k < 300, "wait_col_start", 32'(o_col_n), 32'(coln));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    int a, b;
    i_rst_n     = 1'b0;
    i_key_ready = 1'b1;
    step(3);
    chk(o_col_n == 8'hFE, "rst_col_n", 32'(o_col_n), 32'hFE);
    chk(o_sync == 8'h01, "rst_sync", 32'(o_sync), 32'h01);
    chk(o_key_valid == 1'b0, "rst_valid", 32'(o_key_valid), 0);
    chk(o_key_code == 6'd0, "rst_code", 32'(o_key_code), 0);
    chk(o_overflow == 1'b0, "rst_overflow", 32'(o_overflow), 0);
    chk(o_row_lvl == 8'h00, "rst_row_lvl", 32'(o_row_lvl), 0);
    i_rst_n = 1'b1;

    // Column walk: 16 clocks per column, wrapping after column 7.
    for (int i = 0; i < 144; i++) begin
      e = 8'd1 << ((i / 16) % 8);
      chk(o_col_n == ~e, "col_walk", 32'(o_col_n), 32'(~e));
      chk(o_sync == e, "sync_walk", 32'(o_sync), 32'(e));
      step(1);
    end

    // Single press (2,5).
    exp_q.push_back(6'h15);
    set_key(2, 5, 1'b1);
    step(4 * FRAME);
    wait_col_start(8'hFB);
    chk(o_row_lvl == 8'h20, "press_lvl_col2", 32'(o_row_lvl), 32'h20);
    wait_col_start(8'hF7);
    chk(o_row_lvl == 8'h00, "press_lvl_col3", 32'(o_row_lvl), 0);
    set_key(2, 5, 1'b0);
    step(4 * FRAME);
    wait_col_start(8'hFB);
    chk(o_row_lvl == 8'h00, "release_lvl_col2", 32'(o_row_lvl), 0);

    // Bounce: (0,0) held for exactly two samples.
    wait_col_start(8'hFE);
    set_key(0, 0, 1'b1);
    step(2 * FRAME);
    chk(o_row_lvl == 8'h00, "bounce_lvl_held", 32'(o_row_lvl), 0);
    set_key(0, 0, 1'b0);
    step(2 * FRAME);
    wait_col_start(8'hFE);
    chk(o_row_lvl == 8'h00, "bounce_lvl_after", 32'(o_row_lvl), 0);

    // Two keys in column 3: ascending row order, rows 1 and 6 five EVAL cycles apart.
    exp_q.push_back(6'h19);
    exp_q.push_back(6'h1E);
    set_key(3, 1, 1'b1);
    set_key(3, 6, 1'b1);
    a = -1;
    b = -1;
    for (int k = 0; k < 5 * FRAME && b < 0; k++) begin
      if (o_key_valid) begin
        if (a < 0) a = k;
        else b = k;
      end
      step(1);
    end
    chk(a >= 0 && b - a == 5, "multi_gap", 32'(b - a), 5);
    set_key(3, 1, 1'b0);
    set_key(3, 6, 1'b0);
    step(4 * FRAME);

    // Backpressure: five presses in column order, queue holds the first four.
    i_key_ready = 1'b0;
    wait_col_start(8'hFE);
    exp_q.push_back(6'h02);
    exp_q.push_back(6'h0B);
    exp_q.push_back(6'h24);
    exp_q.push_back(6'h2F);
    set_key(0, 2, 1'b1);
    set_key(1, 3, 1'b1);
    set_key(4, 4, 1'b1);
    set_key(5, 7, 1'b1);
    set_key(6, 0, 1'b1);
    step(4 * FRAME);
    chk(o_overflow == 1'b1, "overflow_set", 32'(o_overflow), 1);
    chk(o_key_valid == 1'b1, "bp_valid", 32'(o_key_valid), 1);
    chk(o_key_code == 6'h02, "bp_head", 32'(o_key_code), 32'h02);
    key_pressed = '0;
    step(4 * FRAME);
    chk(o_key_code == 6'h02, "bp_head_hold", 32'(o_key_code), 32'h02);
    i_key_ready = 1'b1;
    step(10);
    chk(exp_q.size() == 0, "bp_drained", 32'(exp_q.size()), 0);
    chk(o_key_valid == 1'b0, "bp_empty", 32'(o_key_valid), 0);
    chk(o_overflow == 1'b1, "overflow_sticky", 32'(o_overflow), 1);

    // Mid-scan reset with two events queued.
    i_key_ready = 1'b0;
    set_key(7, 2, 1'b1);
    set_key(7, 3, 1'b1);
    step(4 * FRAME);
    chk(o_key_valid == 1'b1, "q2_valid", 32'(o_key_valid), 1);
    chk(o_key_code == 6'h3A, "q2_head", 32'(o_key_code), 32'h3A);
    key_pressed = '0;
    wait_col_start(8'hFE);
    step(6);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk(o_key_valid == 1'b0, "midrst_valid", 32'(o_key_valid), 0);
    chk(o_col_n == 8'hFE, "midrst_col_n", 32'(o_col_n), 32'hFE);
    chk(o_sync == 8'h01, "midrst_sync", 32'(o_sync), 32'h01);
    chk(o_overflow == 1'b0, "midrst_overflow", 32'(o_overflow), 0);
    chk(o_key_code == 6'd0, "midrst_code", 32'(o_key_code), 0);
    step(3);
    i_rst_n     = 1'b1;
    i_key_ready = 1'b1;
    step(15);
    chk(o_col_n == 8'hFE, "post_rst_col0_end", 32'(o_col_n), 32'hFE);
    step(1);
    chk(o_col_n == 8'hFD, "post_rst_col1", 32'(o_col_n), 32'hFD);
    step(3 * FRAME);
    chk(exp_q.size() == 0, "final_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
